// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch
// Description : Instruction-fetch prefetch queue. Issues in-order fetch
//               requests, allocates a queue slot per accepted request,
//               fills slots as responses return and presents the oldest
//               filled slot to decode. A redirect flushes the queue and
//               discards every response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch #(
    parameter int                 PC_SIZE     = 32,
    parameter int                 DATA_WIDTH  = 32,
    parameter int                 QUEUE_DEPTH = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  redirect_in,
    input  logic [PC_SIZE-1:0]    redirect_pc_in,
    output logic                  imem_req_valid_out,
    output logic [PC_SIZE-1:0]    imem_req_addr_out,
    input  logic                  imem_req_ready_in,
    input  logic                  imem_rsp_valid_in,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_in,
    output logic                  inst_valid_out,
    input  logic                  inst_ready_in,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [PC_SIZE-1:0]    pc_out,
    output logic [PC_SIZE-1:0]    pc4_out
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int                 c_PTR_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int                 c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_OCC  = (c_CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [PC_SIZE-1:0] c_PC_STEP    = PC_SIZE'(4);
    localparam logic [PC_SIZE-1:0] c_ALIGN_MASK = ~PC_SIZE'(3);

    if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_queue_depth
        $error("if_prefetch: QUEUE_DEPTH must be a power of two and at least 2");
    end

    logic [c_CNT_W-1:0]    r_alloc_ptr;
    logic [c_CNT_W-1:0]    r_fill_ptr;
    logic [c_CNT_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_drop_cnt;
    logic [PC_SIZE-1:0]    r_fetch_pc;
    logic [PC_SIZE-1:0]    r_pc_mem   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [QUEUE_DEPTH];

    logic [c_CNT_W-1:0]    w_count;
    logic [c_CNT_W-1:0]    w_unfilled;
    logic [c_CNT_W-1:0]    w_drop_redirect;
    logic [c_CNT_W:0]      w_occupancy;
    logic [PC_SIZE-1:0]    w_target;
    logic [PC_SIZE-1:0]    w_head_pc;
    logic                  w_head_filled;
    logic                  w_req_valid;
    logic                  w_alloc;
    logic                  w_fill;
    logic                  w_pop;
    logic                  w_drop_rsp;

    // Allocated entries, and allocated entries still waiting for data.
    assign w_count     = r_alloc_ptr - r_rd_ptr;
    assign w_unfilled  = r_alloc_ptr - r_fill_ptr;

    // Stale responses still in flight reserve queue room just like live ones.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_drop_cnt};
    assign w_req_valid = arst_n & ~redirect_in & (w_occupancy < c_DEPTH_OCC);

    assign imem_req_valid_out = w_req_valid;
    assign imem_req_addr_out  = r_fetch_pc;

    assign w_alloc    = w_req_valid & imem_req_ready_in;
    assign w_drop_rsp = imem_rsp_valid_in & (r_drop_cnt != '0);
    assign w_fill     = imem_rsp_valid_in & (r_drop_cnt == '0) & ~redirect_in
                        & (w_unfilled != '0);

    // Head is filled once the registered fill pointer has moved past it, so a
    // response only becomes visible the cycle after it is written.
    assign w_head_filled  = (r_fill_ptr != r_rd_ptr);
    assign inst_valid_out = w_head_filled & ~redirect_in;
    assign w_pop          = inst_valid_out & inst_ready_in;

    assign w_head_pc = r_pc_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign pc_out    = w_head_filled ? w_head_pc : '0;
    assign pc4_out   = w_head_filled ? (w_head_pc + c_PC_STEP) : '0;
    assign inst_out  = w_head_filled ? r_data_mem[r_rd_ptr[c_PTR_W-1:0]] : '0;

    // Low address bits of the target are forced to zero.
    assign w_target = redirect_pc_in & c_ALIGN_MASK;

    // Everything allocated but unfilled becomes stale; a response landing in
    // the redirect cycle itself is already accounted for and discarded.
    assign w_drop_redirect = r_drop_cnt + w_unfilled - c_CNT_W'(imem_rsp_valid_in);

    // Queue pointers and stale-response counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_drop_cnt  <= '0;
        end else if (redirect_in) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_drop_cnt  <= w_drop_redirect;
        end else begin
            r_alloc_ptr <= r_alloc_ptr + c_CNT_W'(w_alloc);
            r_fill_ptr  <= r_fill_ptr + c_CNT_W'(w_fill);
            r_rd_ptr    <= r_rd_ptr + c_CNT_W'(w_pop);
            r_drop_cnt  <= r_drop_cnt - c_CNT_W'(w_drop_rsp);
        end
    end

    // Fetch address: redirect target wins, otherwise step on each accepted request.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_in) begin
            r_fetch_pc <= w_target;
        end else if (w_alloc) begin
            r_fetch_pc <= r_fetch_pc + c_PC_STEP;
        end
    end

    // Entry storage: pc captured at allocation, instruction captured at fill.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_pc_mem[r_alloc_ptr[c_PTR_W-1:0]] <= r_fetch_pc;
        end
        if (w_fill) begin
            r_data_mem[r_fill_ptr[c_PTR_W-1:0]] <= imem_rsp_data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch
// Description : Self-checking bench for if_prefetch. Directed vector table,
//               hand-written corner sequences and a randomized run checked by
//               a transaction-level scoreboard with an in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_valid_out;
    logic [31:0] imem_req_addr_out;
    logic        imem_req_ready_in;
    logic        imem_rsp_valid_in;
    logic [31:0] imem_rsp_data_in;
    logic        inst_valid_out;
    logic        inst_ready_in;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;

    logic        arst2_n;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        req_valid2;
    logic [31:0] req_addr2;
    logic        req_ready2;
    logic        rsp_valid2;
    logic [31:0] rsp_data2;
    logic        inst_valid2;
    logic        inst_ready2;
    logic [31:0] inst2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    bit rdy_mode = 1'b0;

    if_prefetch #(.PC_SIZE(32), .DATA_WIDTH(32), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .arst_n(arst_n),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .imem_req_valid_out(imem_req_valid_out), .imem_req_addr_out(imem_req_addr_out),
        .imem_req_ready_in(imem_req_ready_in),
        .imem_rsp_valid_in(imem_rsp_valid_in), .imem_rsp_data_in(imem_rsp_data_in),
        .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in),
        .inst_out(inst_out), .pc_out(pc_out), .pc4_out(pc4_out)
    );

    if_prefetch #(.PC_SIZE(32), .DATA_WIDTH(32), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .arst_n(arst2_n),
        .redirect_in(redirect2), .redirect_pc_in(redirect_pc2),
        .imem_req_valid_out(req_valid2), .imem_req_addr_out(req_addr2),
        .imem_req_ready_in(req_ready2),
        .imem_rsp_valid_in(rsp_valid2), .imem_rsp_data_in(rsp_data2),
        .inst_valid_out(inst_valid2), .inst_ready_in(inst_ready2),
        .inst_out(inst2), .pc_out(pc2), .pc4_out(pc4_2)
    );

    initial forever #5 clk = ~clk;

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model + scoreboard. Tracks requests per epoch (an epoch ends
    // at each redirect); responses from an old epoch must never reach
    // decode, and decode must see the program-order address stream.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
        logic [31:0] ep;
    } mreq_t;

    mreq_t mq[$];

    initial begin
        int unsigned cyc;
        int unsigned epoch;
        int          held;
        int          rdy_cnt;
        int          stale;
        logic [31:0] exp_req_pc;
        logic [31:0] exp_pop_pc;
        bit          p_hold;
        logic [31:0] p_pc;
        logic [31:0] p_inst;
        logic        s_rst, s_rv, s_rr, s_iv, s_ir, s_red, s_rspv;
        logic [31:0] s_ra, s_rpc, s_pc, s_pc4, s_inst;
        mreq_t       front;

        cyc = 0; epoch = 0; held = 0; rdy_cnt = 0;
        exp_req_pc = 0; exp_pop_pc = 0; p_hold = 0; p_pc = 0; p_inst = 0;
        imem_req_ready_in = 1'b1;
        imem_rsp_valid_in = 1'b0;
        imem_rsp_data_in  = '0;
        forever begin
            @(negedge clk);
            s_rst = arst_n;        s_rv  = imem_req_valid_out; s_ra   = imem_req_addr_out;
            s_rr  = imem_req_ready_in; s_iv = inst_valid_out;  s_ir   = inst_ready_in;
            s_red = redirect_in;   s_rpc = redirect_pc_in;     s_rspv = imem_rsp_valid_in;
            s_pc  = pc_out;        s_pc4 = pc4_out;            s_inst = inst_out;
            if (!s_rst) begin
                chk("rst_req_valid", {31'b0, s_rv}, 32'd0);
                chk("rst_inst_valid", {31'b0, s_iv}, 32'd0);
                chk("rst_req_addr", s_ra, 32'h0);
                chk("rst_inst_out", s_inst, 32'h0);
                chk("rst_pc_out", s_pc, 32'h0);
                chk("rst_pc4_out", s_pc4, 32'h0);
                p_hold = 0;
            end else begin
                stale = 0;
                foreach (mq[k]) if (mq[k].ep != epoch) stale++;
                chk("sb_req_valid", {31'b0, s_rv}, {31'b0, (!s_red && (held + stale < DEPTH))});
                if (s_rv && s_rr) chk("sb_req_addr", s_ra, exp_req_pc);
                chk("sb_inst_valid", {31'b0, s_iv}, {31'b0, (!s_red && rdy_cnt > 0)});
                if (p_hold && !s_red) begin
                    chk("sb_hold_pc", s_pc, p_pc);
                    chk("sb_hold_inst", s_inst, p_inst);
                end
                if (s_iv && s_ir) begin
                    chk("sb_pop_pc", s_pc, exp_pop_pc);
                    chk("sb_pop_inst", s_inst, mk_inst(exp_pop_pc));
                    chk("sb_pop_pc4", s_pc4, exp_pop_pc + 32'd4);
                end
                p_hold = s_iv && !s_ir;
                p_pc   = s_pc;
                p_inst = s_inst;
            end
            @(posedge clk);
            if (arst_n && s_rst) begin
                if (s_rspv && mq.size() > 0) begin
                    front = mq.pop_front();
                    if (front.ep == epoch && !s_red) rdy_cnt++;
                end
                if (s_red) begin
                    epoch++;
                    held = 0;
                    rdy_cnt = 0;
                    exp_req_pc = s_rpc & ~32'd3;
                    exp_pop_pc = s_rpc & ~32'd3;
                end else begin
                    if (s_rv && s_rr) begin
                        mq.push_back('{addr: s_ra, due: cyc + lat, ep: epoch});
                        held++;
                        exp_req_pc = exp_req_pc + 32'd4;
                    end
                    if (s_iv && s_ir) begin
                        held--;
                        rdy_cnt--;
                        exp_pop_pc = exp_pop_pc + 32'd4;
                    end
                end
            end else begin
                mq.delete();
                epoch++;
                held = 0; rdy_cnt = 0; p_hold = 0;
                exp_req_pc = 32'h0; exp_pop_pc = 32'h0;
            end
            cyc++;
            #1;
            if (arst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid_in = 1'b1;
                imem_rsp_data_in  = mk_inst(mq[0].addr);
            end else begin
                imem_rsp_valid_in = 1'b0;
                imem_rsp_data_in  = $urandom;
            end
            imem_req_ready_in = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RESET_PC at the top of the address space: fetch address wraps.
    // ------------------------------------------------------------------
    initial begin
        arst2_n = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; req_ready2 = 1'b1;
        rsp_valid2 = 1'b0; rsp_data2 = '0; inst_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst2_n = 1'b1;
        @(negedge clk);
        chk("wrap_req0_valid", {31'b0, req_valid2}, 32'd1);
        chk("wrap_req0_addr", req_addr2, 32'hFFFF_FFFC);
        @(posedge clk);
        #1 rsp_valid2 = 1'b1; rsp_data2 = mk_inst(32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_req1_addr", req_addr2, 32'h0);
        chk("wrap_inst_early", {31'b0, inst_valid2}, 32'd0);
        @(posedge clk);
        #1 rsp_valid2 = 1'b0;
        @(negedge clk);
        chk("wrap_inst_valid", {31'b0, inst_valid2}, 32'd1);
        chk("wrap_pc_out", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4_out", pc4_2, 32'h0);
        chk("wrap_inst_out", inst2, mk_inst(32'hFFFF_FFFC));
    end

    // ------------------------------------------------------------------
    // Directed vectors and corner sequences.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rdy;
        logic        red;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [14];

    task automatic reset_dut(input int l);
        @(posedge clk);
        #1 arst_n = 1'b0; redirect_in = 1'b0; lat = l;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    initial begin
        int  fires;
        bit  found;

        // Latency-1 memory, always ready: streaming, stall to full, redirect
        // coinciding with a response arrival and decode ready.
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'hC};
        tbl[9]  = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h0,   1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104};

        arst_n = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0; inst_ready_in = 1'b1;
        lat = 1; rdy_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            inst_ready_in  = tbl[i].rdy;
            redirect_in    = tbl[i].red;
            redirect_pc_in = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("tbl%0d_req_valid", i), {31'b0, imem_req_valid_out}, {31'b0, tbl[i].e_rv});
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr_out, tbl[i].e_ra);
            chk($sformatf("tbl%0d_inst_valid", i), {31'b0, inst_valid_out}, {31'b0, tbl[i].e_iv});
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d_pc_out", i), pc_out, tbl[i].e_pc);
                chk($sformatf("tbl%0d_pc4_out", i), pc4_out, tbl[i].e_pc + 32'd4);
                chk($sformatf("tbl%0d_inst_out", i), inst_out, mk_inst(tbl[i].e_pc));
            end
            @(posedge clk);
            #1;
        end
        redirect_in = 1'b0; inst_ready_in = 1'b1;

        // Decode stalled from reset: queue fills, requests stop, then resume.
        reset_dut(1);
        inst_ready_in = 1'b0;
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req_valid_out && imem_req_ready_in) fires++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stall_fires", fires, 32'd4);
        chk("stall_req_valid", {31'b0, imem_req_valid_out}, 32'd0);
        chk("stall_inst_valid", {31'b0, inst_valid_out}, 32'd1);
        chk("stall_pc_out", pc_out, 32'h0);
        @(posedge clk);
        #1 inst_ready_in = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (imem_req_valid_out && imem_req_ready_in) begin
                found = 1'b1;
                chk("resume_req_addr", imem_req_addr_out, 32'h10);
            end
            @(posedge clk);
            #1;
        end
        if (!found) chk("resume_timeout", 32'd0, 32'd1);

        // Latency 3, two requests in flight when the redirect hits.
        reset_dut(3);
        inst_ready_in = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 redirect_in = 1'b1; redirect_pc_in = 32'h103;
        @(negedge clk);
        chk("redir_req_blocked", {31'b0, imem_req_valid_out}, 32'd0);
        @(posedge clk);
        #1 redirect_in = 1'b0;
        @(negedge clk);
        chk("redir_next_req_valid", {31'b0, imem_req_valid_out}, 32'd1);
        chk("redir_next_req_addr", imem_req_addr_out, 32'h100);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (inst_valid_out) begin
                found = 1'b1;
                chk("redir_first_pc", pc_out, 32'h100);
                chk("redir_first_inst", inst_out, mk_inst(32'h100));
            end
            @(posedge clk);
            #1;
        end
        if (!found) chk("redir_inst_timeout", 32'd0, 32'd1);

        // Asynchronous reset with entries queued.
        reset_dut(1);
        inst_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("prereset_inst_valid", {31'b0, inst_valid_out}, 32'd1);
        @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        chk("arst_req_valid", {31'b0, imem_req_valid_out}, 32'd0);
        chk("arst_inst_valid", {31'b0, inst_valid_out}, 32'd0);
        chk("arst_inst_out", inst_out, 32'h0);
        chk("arst_pc_out", pc_out, 32'h0);
        chk("arst_pc4_out", pc4_out, 32'h0);
        chk("arst_req_addr", imem_req_addr_out, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 arst_n = 1'b1; inst_ready_in = 1'b1;
        @(negedge clk);
        chk("postrst_req_valid", {31'b0, imem_req_valid_out}, 32'd1);
        chk("postrst_req_addr", imem_req_addr_out, 32'h0);
        chk("postrst_inst_valid", {31'b0, inst_valid_out}, 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // Randomized traffic against the scoreboard.
        rdy_mode = 1'b1;
        for (int s = 0; s < 5; s++) begin
            reset_dut(int'($urandom_range(1, 3)));
            for (int c = 0; c < 1500; c++) begin
                inst_ready_in  = ($urandom_range(0, 3) != 0);
                redirect_in    = ($urandom_range(0, 19) == 0);
                redirect_pc_in = $urandom;
                @(posedge clk);
                #1;
            end
        end
        redirect_in = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter PC_SIZE, default 32, width of all program-counter signals.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter QUEUE_DEPTH, default 4, fetch-queue entries; SHALL be a power of two and at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset; word-aligned.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 arst_n  input  1  reset, asynchronous, active-low.
REQ-007 redirect_in  input  1  branch-taken/flush request from execute.
REQ-008 redirect_pc_in  input  PC_SIZE  redirect target; bits [1:0] SHALL be ignored and treated as zero.
REQ-009 imem_req_valid_out  output  1  fetch request valid.
REQ-010 imem_req_addr_out  output  PC_SIZE  fetch address, driven from fetch_pc.
REQ-011 imem_req_ready_in  input  1  memory accepts request.
REQ-012 imem_rsp_valid_in  input  1  response valid; responses arrive in order, at most one per cycle, at least 1 cycle after acceptance, never back-pressured.
REQ-013 imem_rsp_data_in  input  DATA_WIDTH  response instruction.
REQ-014 inst_valid_out  output  1  head instruction valid to decode.
REQ-015 inst_ready_in  input  1  decode accepts; low means decode stalled.
REQ-016 inst_out, pc_out, pc4_out  output  DATA_WIDTH/PC_SIZE/PC_SIZE  head instruction, its address, address+4.

Function
REQ-017 Queue entries SHALL be allocated at request acceptance (storing pc) and filled at response arrival, in order, using alloc, fill and read pointers wrapping modulo QUEUE_DEPTH.
REQ-018 imem_req_valid_out SHALL equal ~redirect_in AND (alloc_count + drop_count < QUEUE_DEPTH), using start-of-cycle counts, with no same-cycle pop bypass.
REQ-019 On request handshake fetch_pc SHALL advance by 4, wrapping modulo 2^PC_SIZE.
REQ-020 A response written at edge N SHALL make its entry visible at the head no earlier than cycle N+1; no combinational rsp-to-inst path.
REQ-021 inst_valid_out SHALL equal head-entry-filled AND ~redirect_in; pc4_out SHALL equal pc_out+4 modulo 2^PC_SIZE.
REQ-022 Pop SHALL occur on inst_valid_out AND inst_ready_in; outputs SHALL stay stable while valid and not ready.
REQ-023 Simultaneous alloc, fill and pop in one cycle SHALL all take effect; sustained throughput SHALL be one instruction per cycle with QUEUE_DEPTH at least latency+1.
REQ-024 In a redirect cycle: no pop, no request, all entries invalidated, fetch_pc loaded with the aligned target at the edge.
REQ-025 On redirect drop_count SHALL become drop_count + (allocated-unfilled entries) - (1 if a non-dropped response arrives that cycle, else 0); that response is discarded.
REQ-026 While drop_count > 0 each arriving response SHALL be discarded and drop_count decremented; it SHALL not fill any entry.
REQ-027 Back-to-back redirects SHALL accumulate drop_count per REQ-025; the last target wins.
REQ-028 Requests SHALL resume the cycle after redirect_in deasserts, subject to REQ-018.

Reset
REQ-029 While arst_n is low: fetch_pc=RESET_PC, queue empty, pointers and drop_count=0, imem_req_valid_out=0, inst_valid_out=0, inst_out/pc_out/pc4_out=0.
REQ-030 In the first cycle after arst_n rises, imem_req_valid_out SHALL be 1 with address RESET_PC; reset mid-operation discards all queued and in-flight state, and the memory model is reset with the block.

Verification
REQ-031 Latency 1, ready always high, inst_ready_in=1 -> requests 0x0,0x4,0x8...; inst_valid_out first high cycle 2 with pc_out=0x0, then one instruction per cycle.
REQ-032 inst_ready_in=0 from reset -> exactly 4 requests accepted, imem_req_valid_out then 0, pc_out held 0x0; release -> pops 0x0..0xC in order, requests resume at 0x10.
REQ-033 Latency 3, two in flight, redirect_in=1 with redirect_pc_in=0x103 -> both stale responses dropped, next request 0x100, next inst_valid_out shows pc_out=0x100.
REQ-034 Redirect in same cycle as response arrival and decode ready -> no pop, response dropped, drop_count counts only remaining in-flight responses.
REQ-035 RESET_PC=0xFFFFFFFC -> second request address 0x0; first instruction pc4_out=0x0.
REQ-036 arst_n pulsed low with 3 entries queued -> outputs 0 immediately; after release first request 0x0 and no pre-reset data emitted.
